// File: rtl/dtw_axis_pkg.sv
// dtw_axis_pkg: shared FSM states and helpers for the DTW stream arbiter
package dtw_axis_pkg;

   typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First requester after 'last' in circular order; bit 4 flags that one was found.
   function automatic logic [4:0] rr_next(input logic [15:0] req, input int last, input int n);
      logic [4:0] r;
      int c;
      r = '0;
      for (int i = 16; i >= 1; i--) begin
         c = (last + i) % n;
         if (i <= n && req[c[3:0]]) r = {1'b1, c[3:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/dtw_axis_if.sv
// dtw_axis_if: AXI-Stream bundle, N lanes wide on the valid/ready/last/user bits
interface dtw_axis_if #(
   parameter int N  = 1,
   parameter int DW = 32,
   parameter int IW = 1
);
   logic [N-1:0]    tvalid;
   logic [N-1:0]    tready;
   logic [N-1:0]    tlast;
   logic [N-1:0]    tuser;
   logic [N*DW-1:0] tdata;
   logic [IW-1:0]   tid;

   modport master (output tvalid, tlast, tuser, tdata, tid, input tready);
   modport slave  (input tvalid, tlast, tuser, tdata, output tready);
endinterface

// File: rtl/dtw_axis_skid.sv
// dtw_axis_skid: two-entry registered skid buffer; o_full depends only on state
module dtw_axis_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_full,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);
   logic [1:0]   r_cnt;
   logic [W-1:0] r_d0, r_d1;
   logic         w_push, w_pop;

   assign o_full  = r_cnt[1];
   assign o_valid = |r_cnt;
   assign o_data  = r_d0;
   assign w_push  = i_valid & ~o_full;
   assign w_pop   = o_valid & i_ready;

   // r_d0 is the head beat; r_d1 only holds the second beat while the head stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_d0  <= '0;
         r_d1  <= '0;
      end else begin
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
         if (w_pop || (w_push && r_cnt == 2'd0)) r_d0 <= r_cnt[1] ? r_d1 : i_data;
         if (w_push && r_cnt == 2'd1) r_d1 <= i_data;
      end
   end
endmodule

// File: rtl/dtw_axis_rr_arbiter.sv
// dtw_axis_rr_arbiter: packet round-robin merge of NUM_CH streams with truncation
module dtw_axis_rr_arbiter import dtw_axis_pkg::*; #(
   parameter  int NUM_CH      = 4,
   parameter  int DATA_WIDTH  = 32,
   parameter  int MAX_PKT_LEN = 4096,
   parameter  int CNT_WIDTH   = 16,
   localparam int CH_ID_WIDTH = id_width(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           ch_enable,
   dtw_axis_if.slave                   s_axis,
   dtw_axis_if.master                  m_axis,
   output logic [NUM_CH*CNT_WIDTH-1:0] pkt_count,
   output logic [NUM_CH-1:0]           trunc_err,
   input  logic [NUM_CH-1:0]           trunc_clr
);
   localparam int BW = (MAX_PKT_LEN > 0) ? $clog2(MAX_PKT_LEN + 1) : 1;
   localparam int PW = DATA_WIDTH + CH_ID_WIDTH + 2;
   localparam logic [BW-1:0] LIM = BW'((MAX_PKT_LEN > 0) ? MAX_PKT_LEN - 1 : 0);

   state_t                             r_state, w_next;
   logic [CH_ID_WIDTH-1:0]             r_grant, r_last;
   logic [BW-1:0]                      r_beat;
   logic [NUM_CH-1:0][CNT_WIDTH-1:0]   r_cnt;
   logic [NUM_CH-1:0]                  r_trunc, w_set;
   logic [4:0]                         w_pick;
   logic                               w_full, w_acc, w_tlast, w_limit, w_push, w_mvalid;
   logic [PW-1:0]                      w_in, w_out;

   assign w_pick  = rr_next(16'(s_axis.tvalid & ch_enable), int'(r_last), NUM_CH);
   assign w_tlast = s_axis.tlast[r_grant];
   assign w_acc   = s_axis.tvalid[r_grant] & s_axis.tready[r_grant];
   assign w_limit = (MAX_PKT_LEN > 0) && (r_beat == LIM);
   assign w_push  = (r_state == PASS) && w_acc;
   assign w_set   = (w_push && !w_tlast && w_limit) ? (NUM_CH'(1) << r_grant) : '0;
   assign w_in    = {r_grant, s_axis.tuser[r_grant], w_tlast | w_limit,
                     s_axis.tdata[r_grant*DATA_WIDTH +: DATA_WIDTH]};

   // Ready comes only from registered state, never from m_axis.tready
   assign s_axis.tready = ((r_state == PASS && !w_full) || r_state == DRAIN) ?
                          (NUM_CH'(1) << r_grant) : '0;

   assign pkt_count = r_cnt;
   assign trunc_err = r_trunc;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next state: one arbitration bubble per packet, truncation diverts to DRAIN
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_pick[4] ? PASS : IDLE;
         PASS:    w_next = !w_acc ? PASS : w_tlast ? IDLE : w_limit ? DRAIN : PASS;
         DRAIN:   w_next = (w_acc && w_tlast) ? IDLE : DRAIN;
         default: w_next = IDLE;
      endcase
   end

   // Grant, beat counter, packet counters and sticky truncation flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant <= '0;
         r_last  <= CH_ID_WIDTH'(NUM_CH - 1);
         r_beat  <= '0;
         r_cnt   <= '0;
         r_trunc <= '0;
      end else begin
         r_trunc <= (r_trunc & ~trunc_clr) | w_set;
         if (r_state == IDLE && w_pick[4]) begin
            r_grant <= w_pick[CH_ID_WIDTH-1:0];
            r_beat  <= '0;
         end else if (w_push) begin
            r_beat <= r_beat + 1'b1;
         end
         if (w_push && (w_tlast || w_limit)) r_cnt[r_grant] <= r_cnt[r_grant] + 1'b1;
         if (r_state != IDLE && w_next == IDLE) r_last <= r_grant;
      end
   end

   dtw_axis_skid #(.W(PW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_push),
      .i_data  (w_in),
      .o_full  (w_full),
      .o_valid (w_mvalid),
      .i_ready (m_axis.tready[0]),
      .o_data  (w_out)
   );

   assign m_axis.tvalid = w_mvalid;
   assign {m_axis.tid, m_axis.tuser, m_axis.tlast, m_axis.tdata} = w_out;
endmodule

// File: doc/dtw_axis_rr_arbiter.md
Name: dtw_axis_rr_arbiter

Overview:
Packet-granular round-robin arbiter merging NUM_CH AXI-Stream sources into the single SRC stream port of the DTW accelerator. Each output beat carries the index of its source channel. Per-channel packet counters are provided. An optional maximum packet length truncates runaway packets and drains their remainder. The block sits between the DMA/signal-ingest channels and the accelerator, all on one stream clock.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_WIDTH, 32, tdata width per channel
MAX_PKT_LEN, 4096, beats per packet before forced truncation; 0 disables the limit
CNT_WIDTH, 16, width of each per-channel packet counter
CH_ID_WIDTH, $clog2(NUM_CH), localparam; width of m_axis_tid

Ports:
clk  in  1  stream clock
rst  in  1  asynchronous, active-high reset
ch_enable  in  NUM_CH  per-channel arbitration enable
s_axis_tvalid  in  NUM_CH  per-channel valid
s_axis_tready  out  NUM_CH  per-channel ready
s_axis_tlast  in  NUM_CH  per-channel last
s_axis_tuser  in  NUM_CH  per-channel user bit, passed through
s_axis_tdata  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
m_axis_tvalid  out  1  merged valid
m_axis_tready  in  1  merged ready
m_axis_tlast  out  1  merged last; forced on truncation
m_axis_tuser  out  1  passed-through user bit
m_axis_tdata  out  DATA_WIDTH  merged data
m_axis_tid  out  CH_ID_WIDTH  source channel of the current beat
pkt_count  out  NUM_CH*CNT_WIDTH  packets forwarded per channel; wraps modulo 2^CNT_WIDTH
trunc_err  out  NUM_CH  sticky per-channel truncation flag
trunc_clr  in  NUM_CH  clears the matching trunc_err bit

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high; it is applied asynchronously and released synchronously to clk by the upstream reset logic.
- Reset values: all outputs 0. s_axis_tready=0, m_axis_tvalid=0, pkt_count=0, trunc_err=0. FSM in IDLE; last_grant=NUM_CH-1, so channel 0 has first priority.
- FSM states:
  - IDLE: search channels in order last_grant+1, last_grant+2, ... (mod NUM_CH) for the first with ch_enable & s_axis_tvalid. Register it as grant and go to PASS. Every s_axis_tready is 0 in IDLE, so arbitration costs one bubble cycle per packet.
  - PASS: s_axis_tready[grant] = !skid_full; all other tready bits are 0.
    - Accepted beat with tlast: increment pkt_count[grant], set last_grant=grant, go to IDLE.
    - Accepted beat without tlast, with MAX_PKT_LEN!=0 and beat_cnt==MAX_PKT_LEN-1: forward the beat with m_axis_tlast forced to 1, set trunc_err[grant], increment pkt_count[grant], go to DRAIN.
  - DRAIN: s_axis_tready[grant]=1 and beats are discarded. On the accepted tlast, set last_grant=grant and go to IDLE.
- beat_cnt: clears on entry to PASS and counts accepted beats. Its width is $clog2(MAX_PKT_LEN+1), minimum 1.
- Output path: two-entry skid buffer, fully registered. There is no combinational path from m_axis_tready to s_axis_tready.
  - Latency from input acceptance to m_axis_tvalid is 1 cycle.
  - Sustained throughput is 1 beat/cycle within a packet.
  - tdata, tuser and tid are held stable while tvalid=1 and tready=0.
- ch_enable changes mid-packet are ignored until the packet ends; they affect only the next arbitration.
- trunc_clr and a new truncation on the same bit in the same cycle: set wins.
- pkt_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- A packet of one beat (tlast on the first beat) is legal.
- MAX_PKT_LEN=1 with no tlast: the single beat is forwarded with forced tlast, then the FSM goes to DRAIN.
- rst asserted mid-packet: all state clears immediately, the partial packet is lost, and the skid contents are discarded.

Decomposition:
- Package dtw_axis_pkg holds:
  - FSM state enum (IDLE, PASS, DRAIN)
  - round-robin next-index function
  - CH_ID_WIDTH helper
- One sub-module, dtw_axis_skid: a two-entry registered skid buffer parametrised on payload width (DATA_WIDTH+CH_ID_WIDTH+2). The arbiter instantiates it once.

Test Plan:
- Fairness: all 4 channels continuously valid with 3-beat packets, m_axis_tready=1 -> tid sequence 0,0,0,1,1,1,2,2,2,3,3,3,0... with one bubble between packets; pkt_count each=1 after the first 12 beats.
- Backpressure: channel 2 sends an 8-beat packet 0xA0..0xA7 while m_axis_tready toggles 1,0,0,1... -> output data in order, none lost or duplicated, payload stable while stalled, tlast only on 0xA7.
- Truncation: MAX_PKT_LEN=4, channel 1 sends 6 beats (tlast on beat 6) -> 4 beats out, the 4th with tlast=1; trunc_err=4'b0010; beats 5-6 drained with s_axis_tready[1]=1; pkt_count[1]=1; trunc_clr[1] pulse -> trunc_err=0.
- Enable masking: ch_enable=4'b1010 with all channels valid -> only tid 1 and 3 granted, alternating; dropping ch_enable[1] mid-packet still completes that packet.
- Counter wrap: CNT_WIDTH=2, channel 0 sends 5 one-beat packets -> pkt_count[0] reads 1,2,3,0,1.
- Reset mid-packet: rst asserted after beat 2 of 5 -> m_axis_tvalid=0 and all s_axis_tready=0 at once; after release the next grant goes to channel 0 and pkt_count=0.
